// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_INS = 3'd1,
        FETCH_EXT = 3'd2,
        ISSUE     = 3'd3,
        WAIT_PC   = 3'd4
    } fetch_state_t;

    // Number of words occupied by an instruction: 2 when its extension bit is set.
    function automatic logic [1:0] ins_len(input logic [WORD_W-1:0] word,
                                           input logic [3:0]        ext_bit);
        ins_len = word[ext_bit] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Program memory read port.
// Handshake: the master raises mem_req with a stable mem_addr and holds both
// until the slave answers with mem_ack; mem_rdata is only meaningful in the
// cycle mem_ack=1, and mem_ack is ignored whenever mem_req=0.
interface fetch_if;
    import fetch_pkg::*;

    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: set_pc beats add_pc beats inc_pc.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [WORD_W-1:0] i_pc,
    input  logic [1:0]        i_len,
    input  logic [WORD_W-1:0] i_operand,
    input  logic              i_set,
    input  logic              i_add,
    input  logic              i_inc,
    output logic [WORD_W-1:0] o_next_pc,
    output logic              o_update
);

    logic [WORD_W-1:0] w_seq_pc;

    // Address of the word following the current instruction (wraps mod 2^16).
    assign w_seq_pc = i_pc + {{(WORD_W-2){1'b0}}, i_len};

    // Pick the new PC by fixed priority; hold the PC when nothing is asserted.
    always_comb begin
        o_next_pc = i_pc;
        o_update  = i_set | i_add | i_inc;
        if (i_set) begin
            o_next_pc = i_operand;
        end else if (i_add) begin
            o_next_pc = w_seq_pc + i_operand;
        end else if (i_inc) begin
            o_next_pc = w_seq_pc;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: reads an instruction word plus optional extension
// word, strobes them to decode, then waits for the PC-control result.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          EXT_BIT  = 15
)(
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              fetch_en,
    fetch_if.master           mem,
    output logic [WORD_W-1:0] ins,
    output logic [WORD_W-1:0] ext,
    output logic              ins_en,
    output logic [WORD_W-1:0] pc,
    output logic              busy,
    input  logic              set_pc,
    input  logic              add_pc,
    input  logic              inc_pc,
    input  logic [WORD_W-1:0] pc_operand,
    output fetch_state_t      dbg_state
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_ins;
    logic [WORD_W-1:0] r_ext;
    logic [WORD_W-1:0] w_next_pc;
    logic              w_update;
    logic [1:0]        w_len;
    logic              w_mem_req;
    logic [WORD_W-1:0] w_mem_addr;

    assign w_len = ins_len(r_ins, 4'(EXT_BIT));

    fetch_next_pc u_next_pc (
        .i_pc      (r_pc),
        .i_len     (w_len),
        .i_operand (pc_operand),
        .i_set     (set_pc),
        .i_add     (add_pc),
        .i_inc     (inc_pc),
        .o_next_pc (w_next_pc),
        .o_update  (w_update)
    );

    // State register plus capture of fetched words and PC updates.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_ins   <= '0;
            r_ext   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                FETCH_INS: begin
                    if (mem.mem_ack) begin
                        r_ins <= mem.mem_rdata;
                        if (!mem.mem_rdata[EXT_BIT]) begin
                            r_ext <= '0;
                        end
                    end
                end
                FETCH_EXT: begin
                    if (mem.mem_ack) begin
                        r_ext <= mem.mem_rdata;
                    end
                end
                WAIT_PC: begin
                    if (w_update) begin
                        r_pc <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory request decode; mem_req is purely state-derived
    // so an asynchronous reset drops it at once.
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_addr   = r_pc;
        case (r_state)
            IDLE: begin
                if (fetch_en) begin
                    w_next_state = FETCH_INS;
                end
            end
            FETCH_INS: begin
                w_mem_req = 1'b1;
                if (mem.mem_ack) begin
                    w_next_state = mem.mem_rdata[EXT_BIT] ? FETCH_EXT : ISSUE;
                end
            end
            FETCH_EXT: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_pc + 16'd1;
                if (mem.mem_ack) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT_PC;
            end
            WAIT_PC: begin
                if (w_update) begin
                    w_next_state = fetch_en ? FETCH_INS : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = w_mem_addr;
    assign ins          = r_ins;
    assign ext          = r_ext;
    assign ins_en       = (r_state == ISSUE);
    assign pc           = r_pc;
    assign busy         = (r_state != IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch.sv
// Directed testbench for the fetch unit with a behavioural program memory.
module tb_fetch;
    import fetch_pkg::*;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        fetch_en;
    logic [15:0] ins;
    logic [15:0] ext;
    logic        ins_en;
    logic [15:0] pc;
    logic        busy;
    logic        set_pc;
    logic        add_pc;
    logic        inc_pc;
    logic [15:0] pc_operand;
    fetch_state_t dbg_state;

    fetch_if mem_if ();

    fetch #(.RESET_PC(16'h0010), .EXT_BIT(15)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .fetch_en   (fetch_en),
        .mem        (mem_if),
        .ins        (ins),
        .ext        (ext),
        .ins_en     (ins_en),
        .pc         (pc),
        .busy       (busy),
        .set_pc     (set_pc),
        .add_pc     (add_pc),
        .inc_pc     (inc_pc),
        .pc_operand (pc_operand),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // ---------------- memory model ----------------
    logic [15:0] mem_arr [0:65535];
    int          ack_delay;
    int          wait_cnt;
    logic        resp_ack;
    logic        force_ack;
    logic        prev_req;
    logic [15:0] prev_addr;

    assign mem_if.mem_rdata = mem_arr[mem_if.mem_addr];
    assign mem_if.mem_ack   = resp_ack | force_ack;

    // Ack a request after ack_delay idle cycles; a new address restarts the wait.
    always @(negedge cpu_clk) begin
        if (mem_if.mem_req) begin
            if (!prev_req || mem_if.mem_addr != prev_addr) wait_cnt = 0;
            else wait_cnt = wait_cnt + 1;
            resp_ack = (wait_cnt >= ack_delay);
        end else begin
            wait_cnt = 0;
            resp_ack = 1'b0;
        end
        prev_req  = mem_if.mem_req;
        prev_addr = mem_if.mem_addr;
    end

    // ---------------- scoreboard ----------------
    logic [47:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(negedge cpu_clk);
    endtask

    task automatic push_exp(input logic [15:0] e_ins, input logic [15:0] e_ext, input logic [15:0] e_pc);
        exp_q.push_back({e_ins, e_ext, e_pc});
    endtask

    // Wait for the ins_en strobe, compare against the oldest expectation,
    // then confirm the strobe lasted one cycle and the unit waits for PC control.
    task automatic wait_issue(input string tag);
        bit seen;
        logic [47:0] e;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ins_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_strobe_seen"}, 48'(seen), 48'd1);
        if (seen) begin
            if (exp_q.size() == 0) begin
                check({tag, "_exp_available"}, 48'd0, 48'(1));
            end else begin
                e = exp_q.pop_front();
                check({tag, "_ins_ext_pc"}, {ins, ext, pc}, e);
            end
        end
        tick();
        check({tag, "_strobe_one_cycle"}, 48'(ins_en), 48'd0);
        check({tag, "_wait_pc_state"}, 48'(dbg_state), 48'(WAIT_PC));
    endtask

    // Drive one PC-control request for a single cycle while in WAIT_PC.
    task automatic pc_ctl(input logic s, input logic a, input logic n, input logic [15:0] opnd);
        set_pc     = s;
        add_pc     = a;
        inc_pc     = n;
        pc_operand = opnd;
        tick();
        set_pc = 1'b0;
        add_pc = 1'b0;
        inc_pc = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [15:0] addr);
        check({tag, "_req"},  48'(mem_if.mem_req), 48'd1);
        check({tag, "_addr"}, 48'(mem_if.mem_addr), 48'(addr));
    endtask

    task automatic wait_addr(input logic [15:0] addr, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (mem_if.mem_req === 1'b1 && mem_if.mem_addr === addr) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   48'(mem_if.mem_req), 48'd0);
        check({tag, "_addr"},  48'(mem_if.mem_addr), 48'h0010);
        check({tag, "_pc"},    48'(pc), 48'h0010);
        check({tag, "_insext"}, {ins, ext}, 48'd0);
        check({tag, "_ins_en"}, 48'(ins_en), 48'd0);
        check({tag, "_busy"},  48'(busy), 48'd0);
        check({tag, "_state"}, 48'(dbg_state), 48'(IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
        cpu_rst    = 1'b0;
        fetch_en   = 1'b1;
        set_pc     = 1'b0;
        add_pc     = 1'b0;
        inc_pc     = 1'b0;
        pc_operand = 16'h0000;
        ack_delay  = 0;
        force_ack  = 1'b0;
        resp_ack   = 1'b0;
        prev_req   = 1'b0;
        prev_addr  = 16'h0000;
        wait_cnt   = 0;

        // Test 1: reset state, zero-wait 1-word fetch, inc_pc
        mem_arr[16'h0010] = 16'h1234;
        mem_arr[16'h0011] = 16'h0042;
        tick();
        tick();
        check_reset_outputs("t1_reset");
        push_exp(16'h1234, 16'h0000, 16'h0010);
        cpu_rst = 1'b1;
        tick();
        check_req("t1_first_fetch", 16'h0010);
        wait_issue("t1_issue");
        push_exp(16'h0042, 16'h0000, 16'h0011);
        pc_ctl(1'b0, 1'b0, 1'b1, 16'h0000);
        check_req("t1_inc", 16'h0011);
        wait_issue("t1_issue2");

        // Test 2: 2-word instruction with 3-cycle ack delay; PC controls ignored while fetching
        mem_arr[16'h0020] = 16'h8001;
        mem_arr[16'h0021] = 16'hBEEF;
        mem_arr[16'h0022] = 16'h0007;
        ack_delay = 3;
        push_exp(16'h8001, 16'hBEEF, 16'h0020);
        pc_ctl(1'b1, 1'b0, 1'b0, 16'h0020);
        check_req("t2_ins", 16'h0020);
        set_pc     = 1'b1;
        pc_operand = 16'h5555;
        wait_addr(16'h0021, n);
        check("t2_ins_wait_cycles", 48'(n), 48'd4);
        check_req("t2_ext", 16'h0021);
        set_pc = 1'b0;
        wait_issue("t2_issue");
        ack_delay = 0;
        push_exp(16'h0007, 16'h0000, 16'h0022);
        pc_ctl(1'b0, 1'b0, 1'b1, 16'h0000);
        check_req("t2_inc", 16'h0022);
        wait_issue("t2_issue2");

        // Test 3: add_pc with negative offset, set_pc beats add_pc, add_pc beats inc_pc
        mem_arr[16'h0030] = 16'h1111;
        mem_arr[16'h002F] = 16'h2222;
        mem_arr[16'h0100] = 16'h3333;
        mem_arr[16'h0111] = 16'h4444;
        push_exp(16'h1111, 16'h0000, 16'h0030);
        pc_ctl(1'b1, 1'b0, 1'b0, 16'h0030);
        wait_issue("t3_issue_30");
        push_exp(16'h2222, 16'h0000, 16'h002F);
        pc_ctl(1'b0, 1'b1, 1'b0, 16'hFFFE);
        check_req("t3_add_neg", 16'h002F);
        wait_issue("t3_issue_2f");
        push_exp(16'h3333, 16'h0000, 16'h0100);
        pc_ctl(1'b1, 1'b1, 1'b0, 16'h0100);
        check_req("t3_set_over_add", 16'h0100);
        wait_issue("t3_issue_100");
        push_exp(16'h4444, 16'h0000, 16'h0111);
        pc_ctl(1'b0, 1'b1, 1'b1, 16'h0010);
        check_req("t3_add_over_inc", 16'h0111);
        wait_issue("t3_issue_111");

        // Test 4: address wrap on the extension word and on inc_pc
        mem_arr[16'hFFFF] = 16'h8ABC;
        mem_arr[16'h0000] = 16'h5678;
        mem_arr[16'h0001] = 16'h0055;
        push_exp(16'h8ABC, 16'h5678, 16'hFFFF);
        pc_ctl(1'b1, 1'b0, 1'b0, 16'hFFFF);
        check_req("t4_ins", 16'hFFFF);
        tick();
        check_req("t4_ext_wrap", 16'h0000);
        wait_issue("t4_issue");
        push_exp(16'h0055, 16'h0000, 16'h0001);
        pc_ctl(1'b0, 1'b0, 1'b1, 16'h0000);
        check_req("t4_inc_wrap", 16'h0001);
        wait_issue("t4_issue2");

        // Test 5: asynchronous reset during FETCH_EXT, stale ack after release
        mem_arr[16'h0040] = 16'h9000;
        mem_arr[16'h0041] = 16'h0ABC;
        ack_delay = 3;
        pc_ctl(1'b1, 1'b0, 1'b0, 16'h0040);
        wait_addr(16'h0041, n);
        tick();
        check("t5_pre_reset_state", 48'(dbg_state), 48'(FETCH_EXT));
        check("t5_pre_reset_req", 48'(mem_if.mem_req), 48'd1);
        #2;
        cpu_rst = 1'b0;
        #1;
        check_reset_outputs("t5_async_reset");
        fetch_en = 1'b0;
        tick();
        cpu_rst   = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check("t5_stale_ack_state", 48'(dbg_state), 48'(IDLE));
        check("t5_stale_ack_ins", 48'(ins), 48'h0);
        check("t5_stale_ack_req", 48'(mem_if.mem_req), 48'd0);
        ack_delay = 0;
        fetch_en  = 1'b1;
        push_exp(16'h1234, 16'h0000, 16'h0010);
        tick();
        check_req("t5_restart", 16'h0010);
        wait_issue("t5_issue");

        // Test 6: fetch_en low does not abort a fetch; it parks the unit in IDLE
        ack_delay = 2;
        mem_arr[16'h0012] = 16'h0066;
        push_exp(16'h0042, 16'h0000, 16'h0011);
        pc_ctl(1'b0, 1'b0, 1'b1, 16'h0000);
        check_req("t6_fetch", 16'h0011);
        fetch_en = 1'b0;
        wait_issue("t6_issue");
        pc_ctl(1'b0, 1'b0, 1'b1, 16'h0000);
        check("t6_idle_state", 48'(dbg_state), 48'(IDLE));
        check("t6_idle_busy", 48'(busy), 48'd0);
        check("t6_idle_pc", 48'(pc), 48'h0012);
        tick();
        tick();
        check("t6_idle_no_req", 48'(mem_if.mem_req), 48'd0);
        push_exp(16'h0066, 16'h0000, 16'h0012);
        fetch_en = 1'b1;
        tick();
        check("t6_resume_state", 48'(dbg_state), 48'(FETCH_INS));
        check_req("t6_resume", 16'h0012);
        wait_issue("t6_issue2");

        check("final_queue_empty", 48'(exp_q.size()), 48'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction fetch unit that feeds decode. It reads one or two 16-bit words per instruction from the program memory port: an instruction word plus an optional extension word. It presents them to decode as ins/ext with a single-cycle ins_en strobe. It then waits for the PC-control result (set/add/inc) from decode/execute before fetching the next instruction.

Parameters:
RESET_PC, 16'h0000, instruction address loaded on reset
EXT_BIT, 15, bit of the instruction word that, when 1, marks that an extension word follows

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rst  in  1  reset, asynchronous, active-low
fetch_en  in  1  permits starting a new instruction fetch
mem_req  out  1  memory read request, held until acked
mem_addr  out  16  memory read address, stable while mem_req=1
mem_ack  in  1  read completes this cycle; sampled only while mem_req=1
mem_rdata  in  16  read data, valid when mem_ack=1
ins  out  16  instruction word to decode
ext  out  16  extension word (0 when the instruction has none)
ins_en  out  1  one-cycle strobe: ins/ext valid
pc  out  16  address of the instruction currently presented
busy  out  1  1 in any state except IDLE
set_pc  in  1  next pc = pc_operand
add_pc  in  1  next pc = pc + len + pc_operand
inc_pc  in  1  next pc = pc + len
pc_operand  in  16  target or offset for set_pc/add_pc

Behaviour:
- Reset (cpu_rst=0, async): state IDLE; mem_req=0; mem_addr=RESET_PC; pc=RESET_PC; ins=0; ext=0; ins_en=0; busy=0. mem_req drops immediately, even mid-transaction. A pending ack after release is ignored.
- len = 1 + ins[EXT_BIT]. All address arithmetic is modulo 2^16 and wraps 16'hFFFF->16'h0000.
- States:
  - IDLE: if fetch_en=1 -> FETCH_INS next cycle with mem_addr=pc.
  - FETCH_INS: mem_req=1, mem_addr=pc. On mem_ack, capture ins<=mem_rdata.
    - If mem_rdata[EXT_BIT]=1 -> FETCH_EXT with mem_addr=pc+1.
    - Otherwise ext<=0 -> ISSUE.
  - FETCH_EXT: mem_req=1, mem_addr=pc+1. On mem_ack, ext<=mem_rdata -> ISSUE.
  - ISSUE: ins_en=1 for exactly this cycle -> WAIT_PC. ins/ext/pc hold their values until the next capture.
  - WAIT_PC: waits for a PC-control input.
    - Priority when several are asserted: set_pc > add_pc > inc_pc.
    - On update, pc<=new value, then go to FETCH_INS if fetch_en=1, else IDLE.
    - With no control asserted, stay in WAIT_PC indefinitely.
- PC-control inputs are ignored in every state except WAIT_PC.
- mem_req deasserts in the cycle after the accepting ack. A zero-wait memory (ack in the first req cycle) is legal.
- Minimum latency with zero-wait memory: 1-word instruction = req cycle, then ins_en on the next cycle. 2-word = 2 req cycles, then ins_en.
- fetch_en=0 never aborts an in-flight fetch. It only blocks leaving IDLE and WAIT_PC->FETCH_INS.
- mem_rdata is sampled only on an ack. Ack while mem_req=0 has no effect.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {IDLE, FETCH_INS, FETCH_EXT, ISSUE, WAIT_PC}
  - WORD_W=16
  - function ins_len(word, ext_bit)
- One sub-module, fetch_next_pc: combinational next-PC select from pc, len, pc_operand and set/add/inc with the fixed priority. Instantiated once.

Test Plan:
1. Reset with RESET_PC=16'h0010, fetch_en=1, zero-wait memory, word@0x10=16'h1234 -> mem_addr=0x0010; ins_en 1 cycle later with ins=16'h1234, ext=0, pc=0x0010. Then inc_pc -> next fetch at 0x0011.
2. word@0x20=16'h8001, word@0x21=16'hBEEF, mem_ack delayed 3 cycles on each word -> address 0x21 fetched second; ins=16'h8001, ext=16'hBEEF; single ins_en. inc_pc -> next mem_addr=0x0022.
3. In WAIT_PC at pc=0x0030, 1-word instruction: add_pc with pc_operand=16'hFFFE -> next fetch 0x002F. set_pc and add_pc together with pc_operand=0x0100 -> next fetch 0x0100.
4. pc=16'hFFFF holding a 2-word instruction -> ext fetched from 0x0000. inc_pc -> next fetch at 0x0001.
5. cpu_rst pulsed low during FETCH_EXT with mem_req=1 -> mem_req=0 immediately; all outputs at reset values; fetch restarts at RESET_PC. A stale mem_ack just after release is ignored.
6. fetch_en=0 during FETCH_INS -> that instruction still issues. After inc_pc -> IDLE, busy=0, no mem_req. Raise fetch_en -> FETCH_INS on the next cycle.
